// File: rtl/full_adder_8b_pkg.sv
// Shared ALU definitions: default datapath width and the arithmetic flag bundle
// consumed by the ALU result mux and flag logic.
package full_adder_8b_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{carry: 1'b0, overflow: 1'b0, zero: 1'b0};

endpackage : full_adder_8b_pkg

// File: rtl/full_adder_1b.sv
// Single-bit full-adder cell; the ripple chain in full_adder_8b is built from these.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_s;

    // Sum and carry-out of one bit position
    always_comb begin
        half_s = a ^ b;
        sum    = half_s ^ cin;
        cout   = (a & b) | (cin & half_s);
    end

endmodule : full_adder_1b

// File: rtl/full_adder_8b.sv
// Registered ripple-carry adder: one-cycle-latency sum, carry-out, signed overflow
// and zero flag of input_a + input_b + input_carry.
module full_adder_8b
    import full_adder_8b_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_carry,
    output logic             output_carry,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_overflow,
    output logic             output_zero
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    alu_flags_t       flags_d;
    alu_flags_t       flags_q;

    assign carry_s[0] = input_carry;

    // carry_s[i+1] is the carry out of cell i; the whole chain settles within one cycle
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1b u_cell (
            .a    (input_a[i]),
            .b    (input_b[i]),
            .cin  (carry_s[i]),
            .sum  (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Next-state result and flags from the combinational chain
    always_comb begin
        sum_d            = sum_s;
        flags_d          = FLAGS_RESET;
        flags_d.carry    = carry_s[WIDTH];
        flags_d.overflow = carry_s[WIDTH] ^ carry_s[WIDTH-1];
        if (sum_s == {WIDTH{1'b0}}) begin
            flags_d.zero = 1'b1;
        end else begin
            flags_d.zero = 1'b0;
        end
    end

    // Output registers; reset clears everything including the zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {WIDTH{1'b0}};
            flags_q <= FLAGS_RESET;
        end else begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    assign output_sum      = sum_q;
    assign output_carry    = flags_q.carry;
    assign output_overflow = flags_q.overflow;
    assign output_zero     = flags_q.zero;

endmodule : full_adder_8b

// File: tb/tb_full_adder_8b.sv
// Directed and random self-checking bench for full_adder_8b.
module tb_full_adder_8b;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         input_carry;
    logic         output_carry;
    logic [W-1:0] output_sum;
    logic         output_overflow;
    logic         output_zero;

    int checks = 0;
    int errors = 0;

    // Expected output word packed as {carry, overflow, zero, sum}
    logic [W+2:0] last_exp;

    full_adder_8b #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .input_a         (input_a),
        .input_b         (input_b),
        .input_carry     (input_carry),
        .output_carry    (output_carry),
        .output_sum      (output_sum),
        .output_overflow (output_overflow),
        .output_zero     (output_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+2:0] pack(input logic c, input logic v, input logic z,
                                          input logic [W-1:0] s);
        return {c, v, z, s};
    endfunction

    // Reference: wide addition, overflow from operand/result sign bits
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] r;
        logic       v;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        return {r[W], v, (r[W-1:0] == {W{1'b0}}), r[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [W+2:0] exp);
        logic [W+2:0] got;
        got = {output_carry, output_overflow, output_zero, output_sum};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed c/v/z/sum=%b/%b/%b/%h expected %b/%b/%b/%h", tag,
                   got[W+2], got[W+1], got[W], got[W-1:0],
                   exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    // Drive at negedge, confirm the old result still holds, then check one edge later
    task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W+2:0] exp, input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            input_a     = a;
            input_b     = b;
            input_carry = cin;
            #1;
            check({tag, "_pre"}, last_exp);
            @(posedge clk);
            #1;
            check(tag, exp);
            last_exp = exp;
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst_n       = 1'b0;
        input_a     = 8'hFF;
        input_b     = 8'hFF;
        input_carry = 1'b1;
        last_exp    = pack(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", pack(1'b1, 1'b0, 1'b0, 8'hFF));

        // Asynchronous reset with FF/FF/1 on the inputs and the clock running
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", pack(1'b0, 1'b0, 1'b0, 8'h00));
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", pack(1'b0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", pack(1'b1, 1'b0, 1'b0, 8'hFF));
        last_exp = pack(1'b1, 1'b0, 1'b0, 8'hFF);

        // Corner sweep, each combination held for three cycles
        step("c_00_00_0", 8'h00, 8'h00, 1'b0, pack(1'b0, 1'b0, 1'b1, 8'h00), 3);
        step("c_00_00_1", 8'h00, 8'h00, 1'b1, pack(1'b0, 1'b0, 1'b0, 8'h01), 3);
        step("c_00_FF_0", 8'h00, 8'hFF, 1'b0, pack(1'b0, 1'b0, 1'b0, 8'hFF), 3);
        step("c_00_FF_1", 8'h00, 8'hFF, 1'b1, pack(1'b1, 1'b0, 1'b1, 8'h00), 3);
        step("c_FF_00_0", 8'hFF, 8'h00, 1'b0, pack(1'b0, 1'b0, 1'b0, 8'hFF), 3);
        step("c_FF_00_1", 8'hFF, 8'h00, 1'b1, pack(1'b1, 1'b0, 1'b1, 8'h00), 3);
        step("c_FF_FF_0", 8'hFF, 8'hFF, 1'b0, pack(1'b1, 1'b0, 1'b0, 8'hFE), 3);
        step("c_FF_FF_1", 8'hFF, 8'hFF, 1'b1, pack(1'b1, 1'b0, 1'b0, 8'hFF), 3);

        // Signed overflow
        step("ovf_7F_01", 8'h7F, 8'h01, 1'b0, pack(1'b0, 1'b1, 1'b0, 8'h80), 1);
        step("ovf_80_80", 8'h80, 8'h80, 1'b0, pack(1'b1, 1'b1, 1'b1, 8'h00), 1);
        step("ovf_FF_FF", 8'hFF, 8'hFF, 1'b0, pack(1'b1, 1'b0, 1'b0, 8'hFE), 1);
        step("ovf_80_FF", 8'h80, 8'hFF, 1'b0, pack(1'b1, 1'b1, 1'b0, 8'h7F), 1);

        // Back-to-back operands: each result exactly one edge later
        step("lat_01_02", 8'h01, 8'h02, 1'b0, pack(1'b0, 1'b0, 1'b0, 8'h03), 1);
        step("lat_10_20", 8'h10, 8'h20, 1'b0, pack(1'b0, 1'b0, 1'b0, 8'h30), 1);
        step("lat_F0_0F", 8'hF0, 8'h0F, 1'b1, pack(1'b1, 1'b0, 1'b1, 8'h00), 1);

        // Random regression against the wide-addition reference
        for (int n = 0; n < 10000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            step("random", ra, rb, rc, model(ra, rb, rc), 1);
        end

        // Reset between edges discards the pending result
        step("pre_async", 8'h12, 8'h34, 1'b0, pack(1'b0, 1'b0, 1'b0, 8'h46), 1);
        @(negedge clk);
        input_a     = 8'hAA;
        input_b     = 8'h55;
        input_carry = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", pack(1'b0, 1'b0, 1'b0, 8'h00));
        @(posedge clk);
        #1;
        check("async_no_pending", pack(1'b0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        input_a     = 8'h05;
        input_b     = 8'h03;
        input_carry = 1'b1;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        check("async_release", pack(1'b0, 1'b0, 1'b0, 8'h09));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_full_adder_8b

// File: doc/full_adder_8b.md
Name: full_adder_8b

Overview:
- Registered ripple-carry adder: computes input_a + input_b + input_carry.
- Presents an 8-bit sum and a carry-out one clock after the operands are sampled.
- Basic arithmetic primitive of the 8-bit CPU ALU; feeds the ALU result mux and flag logic.
- One clock; reset is asynchronous and active-low (ports clk and rst_n).

Parameters:
- WIDTH, 8, operand/sum width in bits. All behaviour below is stated for WIDTH=8 and must generalise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- input_a  input  WIDTH  operand A, unsigned or two's complement
- input_b  input  WIDTH  operand B
- input_carry  input  1  carry-in to bit 0
- output_carry  output  1  registered carry-out of the MSB
- output_sum  output  WIDTH  registered sum, modulo 2^WIDTH
- output_overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- output_zero  output  1  registered flag, high when the sum is zero

Behaviour:
- Datapath: chain of WIDTH 1-bit full-adder cells.
  - Cell i: s = a^b^c; co = (a&b)|(c&(a^b)).
  - Cell 0 takes input_carry; cell i takes carry from cell i-1.
- The combinational result {carry, sum} equals the exact (WIDTH+1)-bit value of a + b + cin.
- No truncation other than modulo 2^WIDTH on the sum.
- Registering:
  - On each rising clk edge with rst_n high, all four outputs load the combinational result of the inputs present at that edge.
  - Latency is exactly 1 cycle.
  - Throughput is 1 operation per cycle.
  - No enable and no handshake.
- Reset:
  - rst_n low immediately, independent of clk, forces output_sum=0, output_carry=0, output_overflow=0, output_zero=0.
  - output_zero resets to 0; it is not recomputed during reset.
  - Outputs hold these values while rst_n is low.
  - Inputs present at the first rising edge after release are captured normally.
  - Reset asserted mid-operation discards the pending result.
- Boundaries:
  - All-ones + all-ones + 1 gives sum all-ones, carry 1.
  - All-ones + 0 + 1 wraps to sum 0, carry 1, zero 1.
  - Carry-in propagates through all WIDTH cells in one cycle.
  - No multicycle path is permitted.
- Overflow is computed regardless of operand interpretation. Consumers decide whether to use the carry or the overflow flag.
- Inputs are not registered inside the block; the upstream stage must hold them stable through the setup window.

Decomposition:
- Shared ALU package holds:
  - the default data width constant DATA_W=8;
  - a flag-bundle typedef (carry, overflow, zero) reused by the ALU.
- One natural sub-module: full_adder_1b (a, b, cin -> sum, cout), instantiated WIDTH times via generate.
- The top adds the carry chain, flag logic and output registers.

Test Plan:
- Reset: assert rst_n=0 with inputs FF/FF/1 and clock running -> all outputs 0 immediately and while held. Release -> next edge gives sum FF, carry 1.
- Exhaustive corner sweep:
  - Cycle A,B over {00,FF} and cin over {0,1}, 8 combos, inputs held several cycles.
  - Expected: 00+00+0 -> 00/c0/z1; FF+00+0 -> FF/c0; 00+FF+1 -> 00/c1/z1; FF+FF+0 -> FE/c1; FF+FF+1 -> FF/c1.
- Signed overflow:
  - 7F+01+0 -> sum 80, carry 0, overflow 1.
  - 80+80+0 -> sum 00, carry 1, overflow 1, zero 1.
  - FF+FF+0 -> overflow 0.
- Latency: change operands every cycle (01+02, 10+20, F0+0F+1) -> each result (03, 30, 00/c1) appears exactly one edge later with no skipped or duplicated cycles.
- Random regression: 10k random A, B, cin compared against a reference (A+B+cin) giving a 9-bit result, one cycle delayed; overflow and zero flags are checked too.
- Asynchronous reset mid-stream: assert rst_n between clock edges -> outputs clear without waiting for clk. The previously pending result never appears.
